// File: rtl/ctrl_regs_pkg.sv
// ctrl_regs_pkg: shared definitions for the ctrl_regs_n register block.
//   cmd_e       - command encoding on the host command bus
//   *_BASE/ADDR - byte addresses of the register map
//   WIN_MASK    - byte offset bits inside the CTRL/STAT windows
//   field constants for the per-channel CTRL register, CTRL reset value
package ctrl_regs_pkg;

   typedef enum logic [1:0] {
      CMD_IDLE = 2'b00,
      CMD_WR   = 2'b01,
      CMD_RD   = 2'b10
   } cmd_e;

   localparam int unsigned CTRL_BASE     = 'h00;
   localparam int unsigned STAT_BASE     = 'h40;
   localparam int unsigned IRQ_STAT_ADDR = 'h80;
   localparam int unsigned WM_ADDR       = 'h84;
   localparam int unsigned IRQ_MASK_ADDR = 'h88;
   localparam int unsigned LOCK_ADDR     = 'h8C;
   localparam int unsigned WIN_MASK      = 'h3F;

   localparam int EN_LSB   = 0;
   localparam int EN_W     = 1;
   localparam int PRIO_LSB = 1;
   localparam int PRIO_W   = 2;
   localparam int LEN_LSB  = 3;
   localparam int LEN_W    = 3;
   localparam int CTRL_W   = 6;

   localparam logic [31:0] CTRL_RST = 32'h7;

endpackage

// File: rtl/ctrl_regs_n_if.sv
// ctrl_regs_n_if: host command bus of the ctrl_regs_n block.
//   cmd       - 2'b00 idle, 2'b01 write, 2'b10 read, 2'b11 idle
//   cmd_addr  - byte address, sampled with cmd
//   cmd_wdata - write data, sampled when cmd is write
//   cmd_rdata - registered read data, updated one cycle after a read
//   cmd_err   - one-cycle pulse the cycle after an illegal access
// Bus semantics: no valid/ready pair. A non-idle cmd is a single-cycle
// transaction accepted unconditionally on the rising clock edge; the block
// never back-pressures, and the response (rdata/err) appears the next cycle.
interface ctrl_regs_n_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic [1:0]        cmd;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [DATA_W-1:0] cmd_rdata;
   logic              cmd_err;

   modport master (output cmd, cmd_addr, cmd_wdata, input cmd_rdata, cmd_err);
   modport slave  (input cmd, cmd_addr, cmd_wdata, output cmd_rdata, cmd_err);
endinterface

// File: rtl/ctrl_regs_irq.sv
// ctrl_regs_irq: watermark interrupt logic.
//   clk_i, rstn_i - clock, async active-low reset
//   avail_i       - packed per-channel availability, channel 0 in LSBs
//   wm_i          - watermark; a channel is "below" when avail < wm
//   w1c_i         - per-channel clear strobes from an IRQ_STAT write
//   mask_i        - interrupt mask
//   stat_o        - sticky IRQ_STAT
//   irq_o         - registered OR of stat & mask
module ctrl_regs_irq #(
   parameter int NUM_CH  = 3,
   parameter int AVAIL_W = 8
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic [NUM_CH*AVAIL_W-1:0] avail_i,
   input  logic [AVAIL_W-1:0]        wm_i,
   input  logic [NUM_CH-1:0]         w1c_i,
   input  logic [NUM_CH-1:0]         mask_i,
   output logic [NUM_CH-1:0]         stat_o,
   output logic                      irq_o
);

   logic [NUM_CH-1:0] below;
   logic [NUM_CH-1:0] below_q;
   logic [NUM_CH-1:0] stat_d;
   logic [NUM_CH-1:0] stat_q;
   logic              irq_q;

   always_comb begin
      below = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         below[c] = avail_i[c*AVAIL_W +: AVAIL_W] < wm_i;
      end
      // A new falling crossing overrides a same-cycle clear.
      stat_d = (stat_q & ~w1c_i) | (below & ~below_q);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         below_q <= '0;
         stat_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         below_q <= below;
         stat_q  <= stat_d;
         irq_q   <= |(stat_q & mask_i);
      end
   end

   assign stat_o = stat_q;
   assign irq_o  = irq_q;

endmodule

// File: rtl/ctrl_regs_n.sv
// ctrl_regs_n: MCDF control/status register block for NUM_CH slave channels.
//   clk_i, rstn_i - clock, async active-low reset
//   cmd_if        - host command bus (slave side)
//   slv_avail_i   - packed per-channel FIFO availability, channel 0 in LSBs
//   slv_en_o      - per-channel enable
//   slv_prio_o    - packed 2-bit priorities
//   slv_len_o     - packed 3-bit length codes
//   irq_o         - watermark interrupt
// Optional feature macro: CTRL_REGS_LOCK_EN adds a sticky LOCK register at
// 0x8C that freezes CTRL, WM and LOCK until reset.
module ctrl_regs_n
   import ctrl_regs_pkg::*;
#(
   parameter int NUM_CH  = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 8,
   parameter int AVAIL_W = 8
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   ctrl_regs_n_if.slave              cmd_if,
   input  logic [NUM_CH*AVAIL_W-1:0] slv_avail_i,
   output logic [NUM_CH-1:0]         slv_en_o,
   output logic [NUM_CH*PRIO_W-1:0]  slv_prio_o,
   output logic [NUM_CH*LEN_W-1:0]   slv_len_o,
   output logic                      irq_o
);

   if (DATA_W != 32) begin : g_bad_data_w
      $error("ctrl_regs_n: DATA_W must be 32");
   end
   if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
      $error("ctrl_regs_n: NUM_CH must be 1..8");
   end
   if (AVAIL_W < 1 || AVAIL_W > DATA_W) begin : g_bad_avail_w
      $error("ctrl_regs_n: AVAIL_W must be 1..DATA_W");
   end

   logic              is_wr, is_rd, aligned, idx_ok;
   logic [3:0]        ch_idx;
   logic              hit_ctrl, hit_stat, hit_istat, hit_wm, hit_mask, hit_lock;
   logic              locked;
   logic              ctrl_we, wm_we, mask_we, lock_we, wr_ok, rd_ok;
   logic [CTRL_W-1:0] ctrl_sel;
   logic [AVAIL_W-1:0] avail_sel;
   logic [NUM_CH-1:0] w1c, irq_stat;
   logic [DATA_W-1:0] rdata_d, rdata_q;
   logic              err_d, err_q;
   logic [CTRL_W-1:0] ctrl_q [NUM_CH];
   logic [AVAIL_W-1:0] wm_q;
   logic [NUM_CH-1:0] mask_q;
   logic              unused_wdata;

   // Upper write-data bits are architecturally ignored.
   assign unused_wdata = ^cmd_if.cmd_wdata;

`ifdef CTRL_REGS_LOCK_EN
   logic lock_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         lock_q <= 1'b0;
      end else if (lock_we) begin
         lock_q <= cmd_if.cmd_wdata[0];
      end
   end

   assign locked   = lock_q;
   assign hit_lock = cmd_if.cmd_addr == ADDR_W'(LOCK_ADDR);
`else
   assign locked   = 1'b0;
   assign hit_lock = 1'b0;
`endif

   always_comb begin
      is_wr   = cmd_if.cmd == CMD_WR;
      is_rd   = cmd_if.cmd == CMD_RD;
      ch_idx  = cmd_if.cmd_addr[5:2];
      aligned = cmd_if.cmd_addr[1:0] == 2'b00;
      idx_ok  = int'(ch_idx) < NUM_CH;

      // CTRL/STAT are 64-byte windows; only the first NUM_CH words are mapped.
      hit_ctrl  = aligned && idx_ok &&
                  ((cmd_if.cmd_addr & ~ADDR_W'(WIN_MASK)) == ADDR_W'(CTRL_BASE));
      hit_stat  = aligned && idx_ok &&
                  ((cmd_if.cmd_addr & ~ADDR_W'(WIN_MASK)) == ADDR_W'(STAT_BASE));
      hit_istat = cmd_if.cmd_addr == ADDR_W'(IRQ_STAT_ADDR);
      hit_wm    = cmd_if.cmd_addr == ADDR_W'(WM_ADDR);
      hit_mask  = cmd_if.cmd_addr == ADDR_W'(IRQ_MASK_ADDR);

      ctrl_we = is_wr && hit_ctrl && !locked;
      wm_we   = is_wr && hit_wm   && !locked;
      lock_we = is_wr && hit_lock && !locked;
      mask_we = is_wr && hit_mask;
      w1c     = (is_wr && hit_istat) ? cmd_if.cmd_wdata[NUM_CH-1:0] : '0;

      wr_ok = ctrl_we || wm_we || lock_we || mask_we || (is_wr && hit_istat);
      rd_ok = hit_ctrl || hit_stat || hit_istat || hit_wm || hit_mask || hit_lock;
      err_d = (is_wr && !wr_ok) || (is_rd && !rd_ok);

      ctrl_sel  = '0;
      avail_sel = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (int'(ch_idx) == c) begin
            ctrl_sel  = ctrl_q[c];
            avail_sel = slv_avail_i[c*AVAIL_W +: AVAIL_W];
         end
      end

      // Read data holds between reads; an illegal read returns zero.
      rdata_d = rdata_q;
      if (is_rd) begin
         rdata_d = '0;
         if (hit_ctrl)       rdata_d = DATA_W'(ctrl_sel);
         else if (hit_stat)  rdata_d = DATA_W'(avail_sel);
         else if (hit_istat) rdata_d = DATA_W'(irq_stat);
         else if (hit_wm)    rdata_d = DATA_W'(wm_q);
         else if (hit_mask)  rdata_d = DATA_W'(mask_q);
         else if (hit_lock)  rdata_d = DATA_W'(locked);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
         wm_q    <= '0;
         mask_q  <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            ctrl_q[c] <= CTRL_RST[CTRL_W-1:0];
         end
      end else begin
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (wm_we)   wm_q   <= cmd_if.cmd_wdata[AVAIL_W-1:0];
         if (mask_we) mask_q <= cmd_if.cmd_wdata[NUM_CH-1:0];
         for (int c = 0; c < NUM_CH; c++) begin
            if (ctrl_we && int'(ch_idx) == c) begin
               ctrl_q[c] <= cmd_if.cmd_wdata[CTRL_W-1:0];
            end
         end
      end
   end

   ctrl_regs_irq #(
      .NUM_CH  (NUM_CH),
      .AVAIL_W (AVAIL_W)
   ) u_irq (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .avail_i (slv_avail_i),
      .wm_i    (wm_q),
      .w1c_i   (w1c),
      .mask_i  (mask_q),
      .stat_o  (irq_stat),
      .irq_o   (irq_o)
   );

   for (genvar c = 0; c < NUM_CH; c++) begin : g_out
      assign slv_en_o[c]                     = ctrl_q[c][EN_LSB];
      assign slv_prio_o[c*PRIO_W +: PRIO_W]  = ctrl_q[c][PRIO_LSB +: PRIO_W];
      assign slv_len_o[c*LEN_W +: LEN_W]     = ctrl_q[c][LEN_LSB +: LEN_W];
   end

   assign cmd_if.cmd_rdata = rdata_q;
   assign cmd_if.cmd_err   = err_q;

endmodule

// File: doc/ctrl_regs_n.md
Name: ctrl_regs_n

Overview:
Parametrised MCDF control/status register block for NUM_CH slave channels.
- Decodes the single-cycle command bus (write/read) into per-channel control fields (enable, priority, packet length).
- Exposes per-channel FIFO availability as read-only status.
- Adds a watermark interrupt with sticky write-1-to-clear status, mask register and error flagging.
- Sits between the host command port and the arbiter/formatter/slave-FIFO control inputs.

Parameters:
NUM_CH, 3, number of slave channels; legal 1..8
DATA_W, 32, command data width; fixed at 32 in this generation, checked by elaboration assertion
ADDR_W, 8, command byte-address width
AVAIL_W, 8, width of each slave availability count; legal 1..DATA_W

Ports:
clk_i  in  1  clock, rising edge
rstn_i  in  1  asynchronous active-low reset
cmd_i  in  2  command: 2'b00 IDLE, 2'b01 WR, 2'b10 RD, 2'b11 treated as IDLE
cmd_addr_i  in  ADDR_W  byte address, sampled with cmd_i
cmd_data_i  in  DATA_W  write data, sampled when cmd_i==WR
cmd_data_o  out  DATA_W  registered read data
slv_avail_i  in  NUM_CH*AVAIL_W  packed availability counts, channel 0 in LSBs
slv_en_o  out  NUM_CH  per-channel enable
slv_prio_o  out  NUM_CH*2  packed priority
slv_len_o  out  NUM_CH*3  packed length code
irq_o  out  1  registered OR of (IRQ_STAT & IRQ_MASK)
cmd_err_o  out  1  one-cycle pulse on illegal access

Behaviour:
- Clocking and reset: all state is on clk_i with asynchronous active-low rstn_i.
- Register map (byte addresses; cmd_addr_i[1:0] must be 0):
  - CTRL[ch] at 0x00+4*ch, RW.
    - Fields: [0] en, [2:1] prio, [5:3] len.
    - [31:6] read 0, and writes to them are ignored.
    - Reset value 0x0000_0007 (en=1, prio=3, len=0).
  - STAT[ch] at 0x40+4*ch, RO. Returns zero-extended slv_avail_i slice, sampled at read.
  - IRQ_STAT 0x80: [NUM_CH-1:0] sticky, write-1-to-clear. Reset 0.
  - WM 0x84: [AVAIL_W-1:0] watermark, RW. Reset 0.
  - IRQ_MASK 0x88: [NUM_CH-1:0], RW. Reset 0.
- Write: takes effect on the edge where cmd_i==WR. Outputs reflect the new value the following cycle.
- Read: cmd_data_o updates on the edge where cmd_i==RD (1-cycle latency) and holds until the next RD. It does not change on WR/IDLE. Reset value 0.
- Illegal access, each giving a cmd_err_o pulse on the next cycle:
  - Unmapped address, CTRL/STAT index >= NUM_CH, or misaligned address.
  - Write to STAT.
  - Result: write is ignored; read returns 0 and cmd_data_o is updated to 0.
- Watermark detect, per channel:
  - below[ch] = (avail < WM).
  - A registered copy below_q[ch] resets to 0.
  - IRQ_STAT[ch] sets on the cycle below && !below_q (falling crossing).
  - With WM==0, below is never true, so no interrupts.
- Simultaneous set and W1C on the same bit in the same cycle: set wins.
- Reading IRQ_STAT returns the pre-update value. A read does not clear.
- WM change that makes below go true for a channel counts as a crossing and sets IRQ_STAT.
- irq_o is registered and lags IRQ_STAT/IRQ_MASK by one cycle. Reset 0.
- Reset values: slv_en_o all 1, slv_prio_o all 2'b11, slv_len_o all 0, irq_o 0, cmd_err_o 0, cmd_data_o 0.
- Reset mid-transaction: a command in the same cycle as rstn_i low is lost.

Optional Feature:
CTRL_REGS_LOCK_EN
- Defined:
  - Adds LOCK at 0x8C, [0] lock. Reset 0.
  - Once set, it is clearable only by reset.
  - While locked, writes to CTRL[*], WM and LOCK are ignored and pulse cmd_err_o.
  - IRQ_STAT W1C and IRQ_MASK stay writable.
  - Reads of LOCK return the bit.
- Not defined: 0x8C is unmapped (illegal, err pulse) and there is no lock logic.

Decomposition:
- Package ctrl_regs_pkg holds:
  - cmd_e enum (IDLE/WR/RD).
  - Address offsets: CTRL_BASE, STAT_BASE, IRQ_STAT_ADDR, WM_ADDR, IRQ_MASK_ADDR, LOCK_ADDR.
  - Field LSB/width constants for en/prio/len.
  - CTRL_RST = 32'h7.
- Sub-module ctrl_regs_irq: per-channel below/below_q edge detect, sticky W1C status, masked irq register. Parameters NUM_CH, AVAIL_W.

Test Plan:
- Reset, then RD 0x00/0x04/0x08 -> cmd_data_o = 0x7 each, one cycle after the RD. slv_en_o=3'b111, slv_prio_o=6'b111111, irq_o=0.
- WR 0x04 data 0xFFFF_FF2A -> slv_en_o[1]=0, prio[1]=2'b01, len[1]=3'b101. RD 0x04 -> 0x0000_002A.
- slv_avail_i[0]=20, WR WM=16, WR IRQ_MASK=0x1, drop avail0 to 15 -> IRQ_STAT=0x1, irq_o=1 one cycle later. Hold 15 -> no re-set. WR IRQ_STAT 0x1 -> irq_o=0.
- Same cycle: avail0 crosses below WM and WR IRQ_STAT 0x1 -> IRQ_STAT[0] stays 1.
- WR 0x40 (STAT), RD 0x0C (NUM_CH=3), RD 0x02 -> cmd_err_o pulses each time. RDs return 0 and no register changes.
- With CTRL_REGS_LOCK_EN: WR LOCK=1, then WR 0x00 0x0 -> cmd_err_o=1, CTRL[0] stays 0x7. W1C IRQ_STAT still works. Assert rstn_i low -> LOCK=0.
